// File: rtl/spill_flush_arbiter.sv
// rtl/spill_flush_arbiter.sv - round-robin arbiter with flush sequencing in front of a flushable spill register
module spill_flush_arbiter #(
    parameter  int NumReq      = 4,
    parameter  int DataWidth   = 32,
    parameter  int FlushCycles = 1,
    localparam int IdxWidth    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           valid_i,
    output logic [NumReq-1:0]           ready_o,
    input  logic [NumReq*DataWidth-1:0] data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [DataWidth-1:0]        data_o,
    output logic [IdxWidth-1:0]         idx_o,
    input  logic                        flush_req_i,
    output logic                        flush_ack_o,
    output logic                        flush_o,
    output logic                        busy_o
);

    localparam int                  CntWidth = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
    localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(NumReq - 1);
    localparam logic [CntWidth-1:0] LastCnt  = CntWidth'(FlushCycles - 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [IdxWidth-1:0] r_rr_ptr;
    logic [IdxWidth-1:0] r_lock_idx;
    logic [CntWidth-1:0] r_flush_cnt;

    logic                 w_hi_hit;
    logic                 w_lo_hit;
    logic                 w_any_valid;
    logic [IdxWidth-1:0]  w_hi_idx;
    logic [IdxWidth-1:0]  w_lo_idx;
    logic [IdxWidth-1:0]  w_grant_idx;
    logic [IdxWidth-1:0]  w_sel_idx;
    logic [DataWidth-1:0] w_sel_data;
    logic                 w_flush_last;

    // Round-robin successor; wraps from the last requester back to 0.
    function automatic logic [IdxWidth-1:0] f_next_idx(input logic [IdxWidth-1:0] idx);
        if (idx == LastIdx) begin
            return '0;
        end else begin
            return idx + IdxWidth'(1);
        end
    endfunction

    assign w_flush_last = (r_flush_cnt == LastCnt);

    // Pick the lowest valid index at or above the pointer, else the lowest valid index overall.
    always_comb begin
        w_hi_hit = 1'b0;
        w_lo_hit = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (valid_i[k]) begin
                w_lo_hit = 1'b1;
                w_lo_idx = IdxWidth'(k);
                if (IdxWidth'(k) >= r_rr_ptr) begin
                    w_hi_hit = 1'b1;
                    w_hi_idx = IdxWidth'(k);
                end
            end
        end
        w_any_valid = w_lo_hit;
        w_grant_idx = w_hi_hit ? w_hi_idx : w_lo_idx;
    end

    // Payload mux: locked index while holding a grant, fresh grant otherwise.
    always_comb begin
        w_sel_idx  = (r_state == ST_LOCK) ? r_lock_idx : w_grant_idx;
        w_sel_data = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (w_sel_idx == IdxWidth'(k)) begin
                w_sel_data = data_i[k*DataWidth +: DataWidth];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pointer, lock index and flush counter updates; reset abandons any grant or flush in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr    <= '0;
            r_lock_idx  <= '0;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    r_flush_cnt <= '0;
                    if (!flush_req_i && w_any_valid) begin
                        if (ready_i) begin
                            r_rr_ptr <= f_next_idx(w_grant_idx);
                        end else begin
                            r_lock_idx <= w_grant_idx;
                        end
                    end
                end
                ST_LOCK: begin
                    if (ready_i) begin
                        r_rr_ptr <= f_next_idx(r_lock_idx);
                    end
                end
                ST_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + CntWidth'(1);
                    if (w_flush_last) begin
                        r_rr_ptr <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic: flush wins in ARB, an unaccepted grant locks, LOCK waits for ready.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ARB: begin
                if (flush_req_i) begin
                    w_next_state = ST_FLUSH;
                end else if (w_any_valid && !ready_i) begin
                    w_next_state = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (ready_i) begin
                    w_next_state = ST_ARB;
                end
            end
            ST_FLUSH: begin
                if (w_flush_last) begin
                    w_next_state = ST_ARB;
                end
            end
            default: begin
                w_next_state = ST_ARB;
            end
        endcase
    end

    // Outputs: all forced low during reset; flush and valid never share a cycle.
    always_comb begin
        valid_o     = 1'b0;
        ready_o     = '0;
        data_o      = '0;
        idx_o       = '0;
        flush_o     = 1'b0;
        flush_ack_o = 1'b0;
        busy_o      = 1'b0;
        if (!rst_i) begin
            case (r_state)
                ST_ARB: begin
                    if (!flush_req_i) begin
                        if (w_any_valid) begin
                            valid_o = 1'b1;
                            idx_o   = w_sel_idx;
                            data_o  = w_sel_data;
                        end else begin
                            idx_o = r_rr_ptr;
                        end
                    end
                end
                ST_LOCK: begin
                    valid_o = 1'b1;
                    idx_o   = w_sel_idx;
                    data_o  = w_sel_data;
                    busy_o  = 1'b1;
                end
                ST_FLUSH: begin
                    flush_o     = 1'b1;
                    flush_ack_o = w_flush_last;
                    busy_o      = 1'b1;
                end
                default: begin
                end
            endcase
            for (int k = 0; k < NumReq; k++) begin
                ready_o[k] = valid_o && ready_i && (w_sel_idx == IdxWidth'(k));
            end
        end
    end

    // A locked requester must keep valid_i high until its handshake completes.
    a_lock_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == ST_LOCK) |-> valid_i[r_lock_idx]);

endmodule
